// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite register endpoint: NUM_REGS byte-writable control words followed by
// NUM_STATUS read-only status words, with a one-cycle write pulse per control word.
module axi_lite_reg_slave #(
  parameter int NUM_REGS = 4,
  parameter int NUM_STATUS = 2,
  parameter logic [32*NUM_REGS-1:0] RESET_VALS = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [31:0]                axi_awaddr,
  input  logic                       axi_awvalid,
  output logic                       axi_awready,
  input  logic [31:0]                axi_wdata,
  input  logic [3:0]                 axi_wstrb,
  input  logic                       axi_wvalid,
  output logic                       axi_wready,
  output logic                       b_valid,
  input  logic                       b_ready,
  output logic [1:0]                 b_response,
  input  logic [31:0]                axi_araddr,
  input  logic                       axi_arvalid,
  output logic                       axi_arready,
  output logic [31:0]                axi_rdata,
  output logic                       axi_rvalid,
  input  logic                       axi_rready,
  output logic [32*NUM_REGS-1:0]     ctrl_q,
  output logic [NUM_REGS-1:0]        ctrl_wr_pulse,
  input  logic [32*NUM_STATUS-1:0]   status_in
);

  typedef enum logic [1:0] {W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  w_state_t w_state_reg;
  r_state_t r_state_reg;

  logic        awready_reg, wready_reg, bvalid_reg, arready_reg, rvalid_reg;
  logic [1:0]  bresp_reg;
  logic [31:0] rdata_reg;
  logic [29:0] aw_idx_reg;
  logic [31:0] wdata_reg;
  logic [3:0]  wstrb_reg;
  logic [31:0] ctrl_reg [NUM_REGS];
  logic [31:0] ctrl_next [NUM_REGS];
  logic [NUM_REGS-1:0] wr_hit;
  logic [NUM_REGS-1:0] pulse_reg;

  logic        aw_hs, w_hs, ar_hs;
  logic        commit_en;
  logic [29:0] c_idx;
  logic [31:0] c_data;
  logic [3:0]  c_strb;
  logic        c_is_ctrl;
  logic [29:0] rd_idx;
  logic [31:0] rd_word;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^{axi_awaddr[1:0], axi_araddr[1:0]};

  assign aw_hs = axi_awvalid & awready_reg;
  assign w_hs  = axi_wvalid & wready_reg;
  assign ar_hs = axi_arvalid & arready_reg;

  // Select address/data for a commit: whichever half arrives this cycle comes
  // straight from the bus, the other half from the holding registers.
  always_comb begin
    commit_en = 1'b0;
    c_idx     = aw_idx_reg;
    c_data    = wdata_reg;
    c_strb    = wstrb_reg;
    case (w_state_reg)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          commit_en = 1'b1;
          c_idx     = axi_awaddr[31:2];
          c_data    = axi_wdata;
          c_strb    = axi_wstrb;
        end
      end
      W_HAVE_A: begin
        if (w_hs) begin
          commit_en = 1'b1;
          c_data    = axi_wdata;
          c_strb    = axi_wstrb;
        end
      end
      W_HAVE_D: begin
        if (aw_hs) begin
          commit_en = 1'b1;
          c_idx     = axi_awaddr[31:2];
        end
      end
      default: ;
    endcase
  end

  assign c_is_ctrl = (c_idx < 30'(NUM_REGS));

  genvar gi, gb;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      for (gb = 0; gb < 4; gb++) begin : g_byte
        assign ctrl_next[gi][8*gb +: 8] = c_strb[gb] ? c_data[8*gb +: 8] : ctrl_reg[gi][8*gb +: 8];
      end
      assign wr_hit[gi] = commit_en && (c_idx == 30'(gi));
      assign ctrl_q[32*gi +: 32] = ctrl_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) ctrl_reg[i] <= RESET_VALS[32*i +: 32];
      pulse_reg <= '0;
    end else begin
      pulse_reg <= wr_hit;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_hit[i]) ctrl_reg[i] <= ctrl_next[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_state_reg <= W_IDLE;
      awready_reg <= 1'b0;
      wready_reg  <= 1'b0;
      bvalid_reg  <= 1'b0;
      bresp_reg   <= 2'b00;
      aw_idx_reg  <= '0;
      wdata_reg   <= '0;
      wstrb_reg   <= '0;
    end else if (commit_en) begin
      awready_reg <= 1'b0;
      wready_reg  <= 1'b0;
      bvalid_reg  <= 1'b1;
      bresp_reg   <= c_is_ctrl ? 2'b00 : 2'b10;
      w_state_reg <= W_RESP;
    end else begin
      case (w_state_reg)
        W_IDLE: begin
          if (aw_hs) begin
            aw_idx_reg  <= axi_awaddr[31:2];
            awready_reg <= 1'b0;
            w_state_reg <= W_HAVE_A;
          end else if (w_hs) begin
            wdata_reg   <= axi_wdata;
            wstrb_reg   <= axi_wstrb;
            wready_reg  <= 1'b0;
            w_state_reg <= W_HAVE_D;
          end else begin
            awready_reg <= 1'b1;
            wready_reg  <= 1'b1;
          end
        end
        W_RESP: begin
          if (b_ready) begin
            bvalid_reg  <= 1'b0;
            awready_reg <= 1'b1;
            wready_reg  <= 1'b1;
            w_state_reg <= W_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  // Read mux sees ctrl_reg before any same-edge write lands.
  always_comb begin
    rd_idx  = axi_araddr[31:2];
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_idx == 30'(i)) rd_word = ctrl_reg[i];
    end
    for (int j = 0; j < NUM_STATUS; j++) begin
      if (rd_idx == 30'(NUM_REGS + j)) rd_word = status_in[32*j +: 32];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state_reg <= R_IDLE;
      arready_reg <= 1'b0;
      rvalid_reg  <= 1'b0;
      rdata_reg   <= '0;
    end else begin
      case (r_state_reg)
        R_IDLE: begin
          if (ar_hs) begin
            rdata_reg   <= rd_word;
            arready_reg <= 1'b0;
            rvalid_reg  <= 1'b1;
            r_state_reg <= R_DATA;
          end else begin
            arready_reg <= 1'b1;
          end
        end
        R_DATA: begin
          if (axi_rready) begin
            rvalid_reg  <= 1'b0;
            arready_reg <= 1'b1;
            r_state_reg <= R_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  assign axi_awready   = awready_reg;
  assign axi_wready    = wready_reg;
  assign b_valid       = bvalid_reg;
  assign b_response    = bresp_reg;
  assign axi_arready   = arready_reg;
  assign axi_rvalid    = rvalid_reg;
  assign axi_rdata     = rdata_reg;
  assign ctrl_wr_pulse = pulse_reg;

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Bench for axi_lite_reg_slave: transaction-level model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_axi_lite_reg_slave;

  localparam int NUM_REGS = 4;
  localparam int NUM_STATUS = 2;
  localparam logic [127:0] RESET_VALS = {32'hDEAD_BEEF, 32'h0, 32'h0, 32'h1234_5678};
  localparam int TMO = 400;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] axi_awaddr = '0;
  logic        axi_awvalid = 1'b0;
  logic        axi_awready;
  logic [31:0] axi_wdata = '0;
  logic [3:0]  axi_wstrb = '0;
  logic        axi_wvalid = 1'b0;
  logic        axi_wready;
  logic        b_valid;
  logic        b_ready = 1'b0;
  logic [1:0]  b_response;
  logic [31:0] axi_araddr = '0;
  logic        axi_arvalid = 1'b0;
  logic        axi_arready;
  logic [31:0] axi_rdata;
  logic        axi_rvalid;
  logic        axi_rready = 1'b0;
  logic [127:0] ctrl_q;
  logic [3:0]  ctrl_wr_pulse;
  logic [63:0] status_in = {32'h5555_AAAA, 32'hCAFE_F00D};

  always #5 clk = ~clk;

  axi_lite_reg_slave #(
    .NUM_REGS(NUM_REGS), .NUM_STATUS(NUM_STATUS), .RESET_VALS(RESET_VALS)
  ) dut (
    .clk(clk), .rst(rst),
    .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .b_valid(b_valid), .b_ready(b_ready), .b_response(b_response),
    .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rdata(axi_rdata), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
    .ctrl_q(ctrl_q), .ctrl_wr_pulse(ctrl_wr_pulse), .status_in(status_in)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic cmp_en = 1'b0;
  logic rnd_done = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_ctrl [NUM_REGS];
  logic        m_live, m_aw_have, m_w_have, m_b_valid, m_r_valid;
  logic [31:0] m_aw_addr, m_w_data, m_r_data;
  logic [3:0]  m_w_strb;
  logic [1:0]  m_b_resp;
  logic [3:0]  m_pulse;
  logic [127:0] m_ctrl_flat;

  // A channel is ready when live, its half is not parked, and no response is owed.
  logic exp_awready, exp_wready, exp_arready;
  assign exp_awready = m_live && !m_aw_have && !m_b_valid;
  assign exp_wready  = m_live && !m_w_have && !m_b_valid;
  assign exp_arready = m_live && !m_r_valid;

  logic aw_fire, w_fire, ar_fire, commit, c_is_ctrl;
  logic [31:0] c_addr, c_data, c_idx;
  logic [3:0]  c_strb;
  assign aw_fire = axi_awvalid && exp_awready;
  assign w_fire  = axi_wvalid && exp_wready;
  assign ar_fire = axi_arvalid && exp_arready;
  assign commit  = (m_aw_have || aw_fire) && (m_w_have || w_fire);
  assign c_addr  = aw_fire ? axi_awaddr : m_aw_addr;
  assign c_data  = w_fire ? axi_wdata : m_w_data;
  assign c_strb  = w_fire ? axi_wstrb : m_w_strb;
  assign c_idx   = c_addr >> 2;
  assign c_is_ctrl = c_idx < NUM_REGS;

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_flat
    assign m_ctrl_flat[32*gi +: 32] = m_ctrl[gi];
  end

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int k = 0; k < 4; k++) if (s[k]) r[8*k +: 8] = d[8*k +: 8];
    return r;
  endfunction

  function automatic logic [31:0] lookup(input logic [31:0] addr);
    logic [31:0] idx;
    idx = addr >> 2;
    if (idx < NUM_REGS) return m_ctrl[idx];
    if (idx < NUM_REGS + NUM_STATUS) return status_in[32*(idx-NUM_REGS) +: 32];
    return 32'h0;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_live <= 1'b0; m_aw_have <= 1'b0; m_w_have <= 1'b0;
      m_b_valid <= 1'b0; m_r_valid <= 1'b0; m_b_resp <= 2'b00;
      m_r_data <= '0; m_pulse <= '0; m_aw_addr <= '0; m_w_data <= '0; m_w_strb <= '0;
      for (int i = 0; i < NUM_REGS; i++) m_ctrl[i] <= RESET_VALS[32*i +: 32];
    end else begin
      m_live <= 1'b1;
      m_pulse <= (commit && c_is_ctrl) ? (4'b0001 << c_idx) : 4'b0000;
      if (commit) begin
        m_aw_have <= 1'b0;
        m_w_have  <= 1'b0;
        m_b_valid <= 1'b1;
        m_b_resp  <= c_is_ctrl ? 2'b00 : 2'b10;
        if (c_is_ctrl) m_ctrl[c_idx] <= merge(m_ctrl[c_idx], c_data, c_strb);
      end else begin
        if (aw_fire) begin m_aw_have <= 1'b1; m_aw_addr <= axi_awaddr; end
        if (w_fire) begin m_w_have <= 1'b1; m_w_data <= axi_wdata; m_w_strb <= axi_wstrb; end
        if (m_b_valid && b_ready) m_b_valid <= 1'b0;
      end
      if (m_r_valid) begin
        if (axi_rready) m_r_valid <= 1'b0;
      end else if (ar_fire) begin
        m_r_valid <= 1'b1;
        m_r_data  <= lookup(axi_araddr);
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("awready", axi_awready, exp_awready);
      chk("wready", axi_wready, exp_wready);
      chk("arready", axi_arready, exp_arready);
      chk("b_valid", b_valid, m_b_valid);
      if (m_b_valid) chk("b_response", b_response, m_b_resp);
      chk("rvalid", axi_rvalid, m_r_valid);
      if (m_r_valid) chk("rdata", axi_rdata, m_r_data);
      chk("ctrl_q", ctrl_q, m_ctrl_flat);
      chk("ctrl_wr_pulse", ctrl_wr_pulse, m_pulse);
    end
  end

  // ---------------- drivers (called on a falling edge) ----------------
  task automatic send_aw(input logic [31:0] a);
    int n = 0;
    axi_awaddr = a; axi_awvalid = 1'b1;
    while (!axi_awready && n < TMO) begin @(negedge clk); n++; end
    chk("aw_handshake", axi_awready, 1'b1);
    @(negedge clk);
    axi_awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    axi_wdata = d; axi_wstrb = s; axi_wvalid = 1'b1;
    while (!axi_wready && n < TMO) begin @(negedge clk); n++; end
    chk("w_handshake", axi_wready, 1'b1);
    @(negedge clk);
    axi_wvalid = 1'b0;
  endtask

  task automatic send_ar(input logic [31:0] a);
    int n = 0;
    axi_araddr = a; axi_arvalid = 1'b1;
    while (!axi_arready && n < TMO) begin @(negedge clk); n++; end
    chk("ar_handshake", axi_arready, 1'b1);
    @(negedge clk);
    axi_arvalid = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] resp);
    int n = 0;
    fork
      send_aw(a);
      send_w(d, s);
    join
    b_ready = 1'b1;
    while (!b_valid && n < TMO) begin @(negedge clk); n++; end
    chk("b_wait", b_valid, 1'b1);
    resp = b_response;
    @(negedge clk);
    b_ready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d);
    int n = 0;
    send_ar(a);
    axi_rready = 1'b1;
    while (!axi_rvalid && n < TMO) begin @(negedge clk); n++; end
    chk("r_wait", axi_rvalid, 1'b1);
    d = axi_rdata;
    @(negedge clk);
    axi_rready = 1'b0;
  endtask

  function automatic logic [31:0] rnd_addr();
    int unsigned k;
    k = $urandom_range(0, 7);
    if (k < 6) return (k << 2) | $urandom_range(0, 3);
    if (k == 6) return 32'h40;
    return $urandom;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]   resp;
    logic [31:0]  rd;
    logic [127:0] saved;

    repeat (3) @(negedge clk);
    cmp_en = 1'b1;
    chk("rst_awready", axi_awready, 1'b0);
    chk("rst_wready", axi_wready, 1'b0);
    chk("rst_arready", axi_arready, 1'b0);
    chk("rst_ctrl_q", ctrl_q, RESET_VALS);
    chk("rst_b_valid", b_valid, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_awready", axi_awready, 1'b1);
    chk("post_rst_arready", axi_arready, 1'b1);

    // Simultaneous AW/W with partial strobes.
    fork
      send_aw(32'h4);
      send_w(32'hA5A5_1234, 4'b0101);
    join
    chk("t2_ctrl1", ctrl_q[63:32], 32'h00A5_0034);
    chk("t2_pulse", ctrl_wr_pulse, 4'b0010);
    chk("t2_bvalid", b_valid, 1'b1);
    chk("t2_bresp", b_response, 2'b00);
    @(negedge clk);
    chk("t2_pulse_off", ctrl_wr_pulse, 4'b0000);
    b_ready = 1'b1;
    @(negedge clk);
    b_ready = 1'b0;

    // AW well ahead of W, then a held-off response.
    send_aw(32'h0);
    repeat (2) @(negedge clk);
    chk("t3_awready_low", axi_awready, 1'b0);
    chk("t3_no_early_commit", ctrl_q[31:0], 32'h1234_5678);
    send_w(32'hFFFF_FFFF, 4'hF);
    chk("t3_ctrl0", ctrl_q[31:0], 32'hFFFF_FFFF);
    chk("t3_pulse", ctrl_wr_pulse, 4'b0001);
    repeat (5) begin
      chk("t3_bvalid_hold", b_valid, 1'b1);
      @(negedge clk);
    end
    b_ready = 1'b1;
    @(negedge clk);
    b_ready = 1'b0;
    chk("t3_bvalid_done", b_valid, 1'b0);
    chk("t3_awready_back", axi_awready, 1'b1);
    chk("t3_wready_back", axi_wready, 1'b1);

    // Writes to a status word and out of range.
    saved = ctrl_q;
    do_write(32'h10, 32'h0BAD_F00D, 4'hF, resp);
    chk("t4_status_slverr", resp, 2'b10);
    do_write(32'h40, 32'h0BAD_F00D, 4'hF, resp);
    chk("t4_oor_slverr", resp, 2'b10);
    chk("t4_ctrl_unchanged", ctrl_q, saved);

    // Status read with stalled rready; status changes after capture.
    send_ar(32'h10);
    chk("t5_rvalid", axi_rvalid, 1'b1);
    chk("t5_rdata", axi_rdata, 32'hCAFE_F00D);
    status_in[31:0] = 32'h0102_0304;
    repeat (4) begin
      @(negedge clk);
      chk("t5_rdata_hold", axi_rdata, 32'hCAFE_F00D);
    end
    axi_rready = 1'b1;
    @(negedge clk);
    axi_rready = 1'b0;
    chk("t5_rvalid_done", axi_rvalid, 1'b0);
    do_read(32'h100, rd);
    chk("t5_oor_read", rd, 32'h0);
    do_read(32'h14, rd);
    chk("t5_status1", rd, 32'h5555_AAAA);

    // Read and write of the same register committing on one edge.
    fork
      send_aw(32'h8);
      send_w(32'h1111_1111, 4'hF);
      send_ar(32'h8);
    join
    chk("t6_old_value", axi_rdata, 32'h0);
    chk("t6_ctrl2", ctrl_q[95:64], 32'h1111_1111);
    b_ready = 1'b1; axi_rready = 1'b1;
    @(negedge clk);
    b_ready = 1'b0; axi_rready = 1'b0;
    do_read(32'h8, rd);
    chk("t6_new_value", rd, 32'h1111_1111);

    // Randomized concurrent traffic against the model.
    fork
      begin
        fork
          begin
            for (int i = 0; i < 60; i++) begin
              logic [31:0] a, d;
              logic [3:0]  s;
              int d1, d2;
              a = rnd_addr(); d = $urandom; s = 4'($urandom_range(0, 15));
              d1 = $urandom_range(0, 3); d2 = $urandom_range(0, 3);
              fork
                begin repeat (d1) @(negedge clk); send_aw(a); end
                begin repeat (d2) @(negedge clk); send_w(d, s); end
              join
            end
          end
          begin
            for (int i = 0; i < 60; i++) begin
              repeat ($urandom_range(0, 3)) @(negedge clk);
              send_ar(rnd_addr());
            end
          end
        join
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(negedge clk);
          b_ready = 1'($urandom_range(0, 1));
          axi_rready = 1'($urandom_range(0, 1));
          if ($urandom_range(0, 7) == 0) status_in = {$urandom, $urandom};
        end
      end
    join
    b_ready = 1'b1; axi_rready = 1'b1;
    repeat (5) @(negedge clk);
    b_ready = 1'b0; axi_rready = 1'b0;

    // Reset asserted while a response is pending.
    fork
      send_aw(32'hC);
      send_w(32'h7777_7777, 4'hF);
    join
    chk("t7_bvalid", b_valid, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("t7_bvalid_async", b_valid, 1'b0);
    chk("t7_ctrl_reset", ctrl_q, RESET_VALS);
    chk("t7_awready_reset", axi_awready, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t7_awready_back", axi_awready, 1'b1);
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
